// File: rtl/btn_event_reporter.sv
// btn_event_reporter
//   Multi-channel button front end. For each channel it synchronises and debounces the
//   pin, detects press/release edges and counts presses. Pending events are served
//   round-robin and each one is serialised as an ASCII message on a byte stream:
//   'B', '0'+ch, 'P'|'R', press count in uppercase hex (MSD first), CR, LF.
//
// Ports
//   i_clk        system clock
//   i_reset_n    asynchronous active-low reset
//   i_btn        raw asynchronous button pins
//   o_debounced  debounced, polarity-corrected state (1 = pressed)
//   o_tx_stb     byte valid towards the UART
//   o_tx_data    byte towards the UART
//   i_tx_busy    UART busy; a byte is taken on o_tx_stb && !i_tx_busy
//   o_drop       sticky per-channel flag: an event was lost
module btn_event_reporter #(
   parameter int unsigned     NBTN            = 4,
   parameter int unsigned     CNTW            = 16,
   parameter int unsigned     DEBOUNCE_CYCLES = 100000,
   parameter logic [NBTN-1:0] INVERT          = '0,
   parameter bit              REPORT_RELEASE  = 1'b0
) (
   input  logic            i_clk,
   input  logic            i_reset_n,
   input  logic [NBTN-1:0] i_btn,
   output logic [NBTN-1:0] o_debounced,
   output logic            o_tx_stb,
   output logic [7:0]      o_tx_data,
   input  logic            i_tx_busy,
   output logic [NBTN-1:0] o_drop
);

   localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned PtrW   = (NBTN > 1) ? $clog2(NBTN) : 1;
   localparam int unsigned NDig   = CNTW / 4;
   localparam int unsigned NBytes = 5 + NDig;
   localparam int unsigned IdxW   = 4;
   localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StSend = 2'd1;
   localparam logic [1:0] StWait = 2'd2;

   // Input conditioning
   logic [NBTN-1:0] sync1_q, sync2_q;
   logic [DbW-1:0]  db_cnt_q [NBTN];
   logic [DbW-1:0]  db_cnt_d [NBTN];
   logic [NBTN-1:0] deb_q, deb_d, deb_prev_q;
   logic [NBTN-1:0] rise, fall;

   // Event bookkeeping
   logic [NBTN-1:0] pend_press_q, pend_press_d;
   logic [NBTN-1:0] pend_rel_q, pend_rel_d;
   logic [NBTN-1:0] drop_q, drop_d;
   logic [CNTW-1:0] cnt_q [NBTN];
   logic [CNTW-1:0] cnt_d [NBTN];

   // Arbiter / serialiser
   logic [1:0]      state_q, state_d;
   logic [PtrW-1:0] ptr_q, ptr_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic [CNTW-1:0] snap_cnt_q, snap_cnt_d;
   logic            snap_rel_q, snap_rel_d;
   logic [PtrW-1:0] snap_ch_q, snap_ch_d;
   logic            found, sel_rel;
   logic [PtrW-1:0] sel_ch;
   logic [NBTN-1:0] clr_press, clr_rel;
   logic [7:0]      tx_byte;
   logic [31:0]     idx_w;
   logic [CNTW-1:0] shifted;
   logic [3:0]      nib;

   // Debounce: toggle only after DEBOUNCE_CYCLES consecutive disagreeing samples
   always_comb begin
      for (int unsigned ch = 0; ch < NBTN; ch++) begin
         db_cnt_d[ch] = '0;
         deb_d[ch]    = deb_q[ch];
         if (sync2_q[ch] != deb_q[ch]) begin
            if (db_cnt_q[ch] == DbLast) begin
               deb_d[ch] = ~deb_q[ch];
            end else begin
               db_cnt_d[ch] = db_cnt_q[ch] + 1'b1;
            end
         end
      end
   end

   assign rise = deb_q & ~deb_prev_q;
   assign fall = REPORT_RELEASE ? (~deb_q & deb_prev_q) : '0;

   // Round-robin search starting at ptr_q; press beats release on the same channel
   always_comb begin
      int unsigned c;
      logic [PtrW-1:0] cs;
      found  = 1'b0;
      sel_ch = '0;
      c      = 0;
      cs     = '0;
      for (int unsigned i = 0; i < NBTN; i++) begin
         c  = (32'(ptr_q) + i) % NBTN;
         cs = PtrW'(c);
         if (!found && (pend_press_q[cs] || pend_rel_q[cs])) begin
            found  = 1'b1;
            sel_ch = cs;
         end
      end
      sel_rel = found && !pend_press_q[sel_ch];
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      idx_d      = idx_q;
      snap_cnt_d = snap_cnt_q;
      snap_rel_d = snap_rel_q;
      snap_ch_d  = snap_ch_q;
      clr_press  = '0;
      clr_rel    = '0;
      case (state_q)
         StIdle: begin
            if (found) begin
               state_d    = StSend;
               idx_d      = '0;
               snap_cnt_d = cnt_q[sel_ch];
               snap_rel_d = sel_rel;
               snap_ch_d  = sel_ch;
               ptr_d      = (32'(sel_ch) == NBTN - 1) ? '0 : sel_ch + 1'b1;
               if (sel_rel) clr_rel[sel_ch] = 1'b1;
               else         clr_press[sel_ch] = 1'b1;
            end
         end
         StSend: begin
            if (!i_tx_busy) begin
               if (idx_q == IdxW'(NBytes - 1)) state_d = StIdle;
               else                            idx_d   = idx_q + 1'b1;
            end
         end
         StWait:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // A new event on a bit that stays set is lost; a same-cycle set overrides the clear
   always_comb begin
      pend_press_d = rise | (pend_press_q & ~clr_press);
      pend_rel_d   = fall | (pend_rel_q & ~clr_rel);
      drop_d       = drop_q | (rise & pend_press_q & ~clr_press)
                            | (fall & pend_rel_q & ~clr_rel);
      for (int unsigned ch = 0; ch < NBTN; ch++) begin
         cnt_d[ch] = rise[ch] ? cnt_q[ch] + 1'b1 : cnt_q[ch];
      end
   end

   // Message byte for the current index
   always_comb begin
      idx_w   = 32'(idx_q);
      shifted = '0;
      nib     = 4'h0;
      tx_byte = 8'h00;
      if (idx_w == 0) begin
         tx_byte = 8'h42;
      end else if (idx_w == 1) begin
         tx_byte = 8'h30 + 8'(snap_ch_q);
      end else if (idx_w == 2) begin
         tx_byte = snap_rel_q ? 8'h52 : 8'h50;
      end else if (idx_w < 3 + NDig) begin
         shifted = snap_cnt_q >> (4 * (NDig + 2 - idx_w));
         nib     = shifted[3:0];
         tx_byte = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
      end else if (idx_w == 3 + NDig) begin
         tx_byte = 8'h0D;
      end else begin
         tx_byte = 8'h0A;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         deb_q        <= '0;
         deb_prev_q   <= '0;
         pend_press_q <= '0;
         pend_rel_q   <= '0;
         drop_q       <= '0;
         for (int unsigned ch = 0; ch < NBTN; ch++) begin
            db_cnt_q[ch] <= '0;
            cnt_q[ch]    <= '0;
         end
         state_q    <= StIdle;
         ptr_q      <= '0;
         idx_q      <= '0;
         snap_cnt_q <= '0;
         snap_rel_q <= 1'b0;
         snap_ch_q  <= '0;
      end else begin
         sync1_q      <= i_btn ^ INVERT;
         sync2_q      <= sync1_q;
         deb_q        <= deb_d;
         deb_prev_q   <= deb_q;
         pend_press_q <= pend_press_d;
         pend_rel_q   <= pend_rel_d;
         drop_q       <= drop_d;
         for (int unsigned ch = 0; ch < NBTN; ch++) begin
            db_cnt_q[ch] <= db_cnt_d[ch];
            cnt_q[ch]    <= cnt_d[ch];
         end
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         idx_q      <= idx_d;
         snap_cnt_q <= snap_cnt_d;
         snap_rel_q <= snap_rel_d;
         snap_ch_q  <= snap_ch_d;
      end
   end

   assign o_debounced = deb_q;
   assign o_drop      = drop_q;
   assign o_tx_stb    = (state_q == StSend);
   assign o_tx_data   = o_tx_stb ? tx_byte : 8'h00;

endmodule

// File: tb/tb_btn_event_reporter.sv
// tb_btn_event_reporter
//   Directed bench for btn_event_reporter. dut1: 4 channels, 16-bit counters, presses only.
//   dut2: 2 channels, 8-bit counters, releases reported, channel 0 active-low.
module tb_btn_event_reporter;

   logic       clk = 1'b0;
   logic       rst_n, rst2_n;
   logic [3:0] btn, deb, drop;
   logic       stb, busy;
   logic [7:0] data;
   logic [1:0] btn2, deb2, drop2;
   logic       stb2, busy2;
   logic [7:0] data2;

   int checks = 0;
   int errors = 0;

   logic [7:0] q1[$];
   logic [7:0] q2[$];

   always #5 clk = ~clk;

   btn_event_reporter #(
      .NBTN(4), .CNTW(16), .DEBOUNCE_CYCLES(4), .INVERT(4'b0000), .REPORT_RELEASE(1'b0)
   ) dut1 (
      .i_clk(clk), .i_reset_n(rst_n), .i_btn(btn), .o_debounced(deb), .o_tx_stb(stb),
      .o_tx_data(data), .i_tx_busy(busy), .o_drop(drop)
   );

   btn_event_reporter #(
      .NBTN(2), .CNTW(8), .DEBOUNCE_CYCLES(4), .INVERT(2'b01), .REPORT_RELEASE(1'b1)
   ) dut2 (
      .i_clk(clk), .i_reset_n(rst2_n), .i_btn(btn2), .o_debounced(deb2), .o_tx_stb(stb2),
      .o_tx_data(data2), .i_tx_busy(busy2), .o_drop(drop2)
   );

   // Bytes are captured on the falling edge before the rising edge that accepts them
   always @(negedge clk) begin
      if (rst_n && stb && !busy) q1.push_back(data);
      if (rst2_n && stb2 && !busy2) q2.push_back(data2);
   end

   initial begin
      #800000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] mk_msg(input int ch, input bit rel, input int cnt,
                                           input int cntw);
      logic [127:0] m;
      logic [7:0]   b;
      int           n;
      m = '0;
      m = {m[119:0], 8'h42};
      b = 8'h30 + 8'(ch);
      m = {m[119:0], b};
      m = {m[119:0], (rel ? 8'h52 : 8'h50)};
      for (int d = cntw / 4 - 1; d >= 0; d--) begin
         n = (cnt >> (4 * d)) & 15;
         b = (n < 10) ? 8'(48 + n) : 8'(55 + n);
         m = {m[119:0], b};
      end
      m = {m[119:0], 8'h0D};
      m = {m[119:0], 8'h0A};
      return m;
   endfunction

   // Bounded wait for n bytes; a short capture simply mismatches the expected message
   task automatic get_msg(input int sel, input int n, output logic [127:0] m);
      int t;
      m = '0;
      t = 0;
      while (((sel == 1) ? q1.size() : q2.size()) < n && t < 400) begin
         cyc(1);
         t++;
      end
      for (int i = 0; i < n; i++) begin
         if (sel == 1 && q1.size() > 0)      m = {m[119:0], q1.pop_front()};
         else if (sel == 2 && q2.size() > 0) m = {m[119:0], q2.pop_front()};
      end
   endtask

   task automatic expect_msg(input string name, input int sel, input int ch, input bit rel,
                             input int cnt, input int cntw);
      logic [127:0] m;
      get_msg(sel, 5 + cntw / 4, m);
      check(name, m, mk_msg(ch, rel, cnt, cntw));
   endtask

   task automatic wait_q(input int sel, input int n);
      int t;
      t = 0;
      while (((sel == 1) ? q1.size() : q2.size()) < n && t < 200) begin
         cyc(1);
         t++;
      end
      check("wait for bytes", 128'((sel == 1) ? q1.size() >= n : q2.size() >= n), 128'(1));
   endtask

   typedef struct packed {
      logic [3:0] btn;
      logic [7:0] ncyc;
      logic [3:0] deb;
      logic       stb;
      logic [7:0] data;
   } vec_t;

   vec_t tab [16];

   initial begin
      logic       glitch, frozen, s_stb;
      logic [7:0] s_data;

      // Reset idle, then a clean step on channel 2 cycle by cycle through its message
      tab[0]  = '{4'b0000, 8'd10, 4'b0000, 1'b0, 8'h00};
      tab[1]  = '{4'b0000, 8'd20, 4'b0000, 1'b0, 8'h00};
      tab[2]  = '{4'b0100, 8'd5,  4'b0000, 1'b0, 8'h00};
      tab[3]  = '{4'b0100, 8'd1,  4'b0100, 1'b0, 8'h00};
      tab[4]  = '{4'b0100, 8'd1,  4'b0100, 1'b0, 8'h00};
      tab[5]  = '{4'b0100, 8'd1,  4'b0100, 1'b1, 8'h42};
      tab[6]  = '{4'b0100, 8'd1,  4'b0100, 1'b1, 8'h32};
      tab[7]  = '{4'b0100, 8'd1,  4'b0100, 1'b1, 8'h50};
      tab[8]  = '{4'b0100, 8'd1,  4'b0100, 1'b1, 8'h30};
      tab[9]  = '{4'b0100, 8'd1,  4'b0100, 1'b1, 8'h30};
      tab[10] = '{4'b0100, 8'd1,  4'b0100, 1'b1, 8'h30};
      tab[11] = '{4'b0100, 8'd1,  4'b0100, 1'b1, 8'h31};
      tab[12] = '{4'b0100, 8'd1,  4'b0100, 1'b1, 8'h0D};
      tab[13] = '{4'b0100, 8'd1,  4'b0100, 1'b1, 8'h0A};
      tab[14] = '{4'b0100, 8'd1,  4'b0100, 1'b0, 8'h00};
      tab[15] = '{4'b0100, 8'd10, 4'b0100, 1'b0, 8'h00};

      rst_n  = 1'b0;
      rst2_n = 1'b0;
      btn    = 4'b0000;
      btn2   = 2'b01;
      busy   = 1'b0;
      busy2  = 1'b0;
      cyc(3);
      check("reset stb", 128'(stb), 128'(0));
      check("reset data", 128'(data), 128'(8'h00));
      check("reset drop", 128'(drop), 128'(0));
      rst_n  = 1'b1;
      rst2_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         btn = tab[i].btn;
         cyc(int'(tab[i].ncyc));
         check($sformatf("vec%0d debounced", i), 128'(deb), 128'(tab[i].deb));
         check($sformatf("vec%0d stb", i), 128'(stb), 128'(tab[i].stb));
         if (tab[i].stb) check($sformatf("vec%0d data", i), 128'(data), 128'(tab[i].data));
         check($sformatf("vec%0d drop", i), 128'(drop), 128'(0));
      end
      q1.delete();

      // Bouncing channel 0: 3-cycle pulses never pass the filter, the final hold does
      glitch = 1'b0;
      for (int p = 0; p < 10; p++) begin
         btn[0] = 1'b1;
         for (int k = 0; k < 3; k++) begin
            cyc(1);
            if (deb[0]) glitch = 1'b1;
         end
         btn[0] = 1'b0;
         cyc(1);
         if (deb[0]) glitch = 1'b1;
      end
      check("bounce no glitch", 128'(glitch), 128'(0));
      check("bounce no bytes", 128'(q1.size()), 128'(0));
      btn[0] = 1'b1;
      expect_msg("bounce msg", 1, 0, 1'b0, 1, 16);
      cyc(30);
      check("bounce single msg", 128'(q1.size()), 128'(0));

      // Simultaneous presses on 1 and 3, then round-robin from channel 2
      btn[1] = 1'b1;
      btn[3] = 1'b1;
      expect_msg("pair first ch1", 1, 1, 1'b0, 1, 16);
      expect_msg("pair second ch3", 1, 3, 1'b0, 1, 16);
      btn[1] = 1'b0;
      cyc(12);
      btn[1] = 1'b1;
      expect_msg("ch1 second press", 1, 1, 1'b0, 2, 16);
      btn[1] = 1'b0;
      btn[3] = 1'b0;
      cyc(12);
      btn[1] = 1'b1;
      btn[3] = 1'b1;
      expect_msg("rr pair ch3 first", 1, 3, 1'b0, 2, 16);
      expect_msg("rr pair ch1 second", 1, 1, 1'b0, 3, 16);

      // Back-pressure on channel 0 with two more presses during the stall
      btn[0] = 1'b0;
      cyc(12);
      btn[0] = 1'b1;
      wait_q(1, 2);
      busy   = 1'b1;
      s_stb  = stb;
      s_data = data;
      btn[0] = 1'b0;
      frozen = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         cyc(1);
         if (stb !== s_stb || data !== s_data) frozen = 1'b1;
         if (k == 5)  btn[0] = 1'b1;
         if (k == 10) btn[0] = 1'b0;
         if (k == 15) btn[0] = 1'b1;
      end
      busy = 1'b0;
      check("busy stb held", 128'(s_stb), 128'(1));
      check("busy byte is P", 128'(s_data), 128'(8'h50));
      check("busy frozen", 128'(frozen), 128'(0));
      expect_msg("stalled msg", 1, 0, 1'b0, 2, 16);
      expect_msg("after stall", 1, 0, 1'b0, 4, 16);
      check("drop ch0", 128'(drop), 128'(4'b0001));

      // dut2: active-low pin idle high must read as released
      check("dut2 idle debounced", 128'(deb2), 128'(0));
      check("dut2 idle no bytes", 128'(q2.size()), 128'(0));
      for (int p = 0; p < 255; p++) begin
         btn2[0] = 1'b0;
         cyc(7);
         btn2[0] = 1'b1;
         cyc(7);
      end
      cyc(100);
      q2.delete();
      btn2[0] = 1'b0;
      expect_msg("wrap press", 2, 0, 1'b0, 0, 8);
      btn2[0] = 1'b1;
      expect_msg("wrap release", 2, 0, 1'b1, 0, 8);

      // Reset in the middle of a message
      btn2[0] = 1'b0;
      wait_q(2, 4);
      check("pre-reset stb", 128'(stb2), 128'(1));
      rst2_n = 1'b0;
      #1;
      check("reset stb immediate", 128'(stb2), 128'(0));
      check("reset data immediate", 128'(data2), 128'(8'h00));
      check("reset debounced", 128'(deb2), 128'(0));
      check("reset drop2", 128'(drop2), 128'(0));
      cyc(2);
      rst2_n = 1'b1;
      q2.delete();
      expect_msg("post-reset press", 2, 0, 1'b0, 1, 8);
      btn2[0] = 1'b1;
      expect_msg("post-reset release", 2, 0, 1'b1, 1, 8);
      cyc(30);
      check("dut2 no extra", 128'(q2.size()), 128'(0));
      check("dut1 no extra", 128'(q1.size()), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
